// File: rtl/fire7_expand1_ofm_writer.sv
// fire7 expand-1x1 OFM writer: double-buffers 192-channel pixel vectors and writes them as LANES-wide channel-major RAM words.
// Optional sticky overrun detection / feedback gating: define FIRE7_OFM_WRITER_OVERRUN_EN.
module fire7_expand1_ofm_writer #(
  parameter int DSP_NO = 192,
  parameter int WIDTH  = 16,
  parameter int LANES  = 16,
  parameter int WOUT   = 16,
  parameter int BEATS  = DSP_NO / LANES,
  parameter int ADDR_W = $clog2(WOUT * WOUT * BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   layer_clr,
  input  logic                   sample,
  input  logic [WIDTH-1:0]       ofm_in [DSP_NO],
  input  logic                   wr_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [LANES*WIDTH-1:0] wr_data,
  output logic                   ram_feedback,
  output logic                   busy,
  output logic                   overrun
);

  localparam int PIXELS = WOUT * WOUT;
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_W = LANES * WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                        state_q, state_n;
  logic [BEAT_W-1:0]             beat_q;
  logic [PIX_W-1:0]              pix_q;
  logic                          act_full, pend_full, layer_done;
  logic [BEATS-1:0][WORD_W-1:0]  act_buf, pend_buf;
  logic [DSP_NO*WIDTH-1:0]       ofm_flat;

  logic last_beat, last_pix, accept, release_act, take;
  logic act_after, pend_after, load_act, load_pend, move;
  logic act_full_n, pend_full_n;

  // Channel c sits at bits [c*WIDTH +: WIDTH], so beat b of the flat vector is exactly RAM word b.
  for (genvar c = 0; c < DSP_NO; c++) begin : g_flat
    assign ofm_flat[c*WIDTH +: WIDTH] = ofm_in[c];
  end

  always_comb begin
    last_beat   = (beat_q == BEAT_W'(BEATS - 1));
    last_pix    = (pix_q == PIX_W'(PIXELS - 1));
    accept      = (state_q == WRITE) && wr_ready;
    release_act = accept && last_beat;
    // Occupancy as seen after this cycle's last-beat release, so a coinciding sample never drops.
    act_after   = release_act ? pend_full : act_full;
    pend_after  = release_act ? 1'b0 : pend_full;
    take        = sample && !layer_done && (state_q != DONE)
                  && !(release_act && last_pix && !pend_full);
    load_act    = take && !act_after;
    load_pend   = take && act_after && !pend_after;
    move        = release_act && pend_full;
    act_full_n  = act_after | load_act;
    pend_full_n = pend_after | load_pend;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (act_full_n) state_n = WRITE;
      WRITE:   if (release_act) begin
                 if (act_full_n)    state_n = WRITE;
                 else if (last_pix) state_n = DONE;
                 else               state_n = IDLE;
               end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      pix_q      <= '0;
      act_full   <= 1'b0;
      pend_full  <= 1'b0;
      layer_done <= 1'b0;
    end else if (layer_clr) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      pix_q      <= '0;
      act_full   <= 1'b0;
      pend_full  <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      act_full  <= act_full_n;
      pend_full <= pend_full_n;
      if (accept)           beat_q     <= last_beat ? '0 : beat_q + BEAT_W'(1);
      if (release_act)      pix_q      <= pix_q + PIX_W'(1);
      if (state_q == DONE)  layer_done <= 1'b1;
    end
  end

  // Buffer payload needs no reset: it is only observable through wr_data while in WRITE.
  always_ff @(posedge clk) begin
    if (move)      act_buf  <= pend_buf;
    if (load_act)  act_buf  <= ofm_flat;
    if (load_pend) pend_buf <= ofm_flat;
  end

  always_comb begin
    wr_en   = (state_q == WRITE);
    wr_addr = wr_en ? ADDR_W'(beat_q) * ADDR_W'(PIXELS) + ADDR_W'(pix_q) : '0;
    wr_data = wr_en ? act_buf[beat_q] : '0;
    busy    = act_full | pend_full;
  end

`ifdef FIRE7_OFM_WRITER_OVERRUN_EN
  logic drop, overrun_q;
  assign drop = take && act_after && pend_after;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           overrun_q <= 1'b0;
    else if (layer_clr) overrun_q <= 1'b0;
    else if (drop)      overrun_q <= 1'b1;
  end

  assign overrun      = overrun_q;
  assign ram_feedback = (state_q == DONE) && !overrun_q;
`else
  assign overrun      = 1'b0;
  assign ram_feedback = (state_q == DONE);
`endif

endmodule

// File: tb/tb_fire7_expand1_ofm_writer.sv
// Self-checking bench for fire7_expand1_ofm_writer: scoreboard of expected RAM writes plus per-scenario checks.
module tb_fire7_expand1_ofm_writer;

  localparam int DSP_NO = 192;
  localparam int WIDTH  = 16;
  localparam int LANES  = 16;
  localparam int WOUT   = 16;
  localparam int BEATS  = 12;
  localparam int ADDR_W = 12;
  localparam int WORD_W = LANES * WIDTH;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } exp_t;

  logic              clk, rst, layer_clr, sample, wr_ready;
  logic [WIDTH-1:0]  ofm_in [DSP_NO];
  logic              wr_en, ram_feedback, busy, overrun;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   exp_pix = 0;
  int   cyc = 0, wr_en_cycles = 0, run = 0, run_max = 0;
  int   wr_count = 0, last_wr_cyc = 0, fb_count = 0, fb_cyc = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;

  fire7_expand1_ofm_writer #(
    .DSP_NO(DSP_NO), .WIDTH(WIDTH), .LANES(LANES), .WOUT(WOUT),
    .BEATS(BEATS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .layer_clr(layer_clr), .sample(sample), .ofm_in(ofm_in),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_feedback(ram_feedback), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every accepted beat is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (wr_en) begin
      wr_en_cycles++;
      run++;
      if (run > run_max) run_max = run;
    end else run = 0;
    if (wr_en && wr_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write addr=%0d (no write expected)", wr_addr);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          errors++;
          $display("FAIL sb_write addr=%0d data=%h expected addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
      wr_count++;
      last_wr_addr = wr_addr;
      last_wr_cyc  = cyc;
    end
    if (ram_feedback) begin
      fb_count++;
      fb_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sample(input bit expect_write, input bit ramp);
    exp_t e;
    for (int c = 0; c < DSP_NO; c++) ofm_in[c] = ramp ? WIDTH'(c) : WIDTH'($urandom);
    if (expect_write) begin
      for (int b = 0; b < BEATS; b++) begin
        e.addr = ADDR_W'(b * WOUT * WOUT + exp_pix);
        for (int k = 0; k < LANES; k++) e.data[k*WIDTH +: WIDTH] = ofm_in[b*LANES + k];
        sb.push_back(e);
      end
      exp_pix++;
    end
    sample = 1'b1;
    step();
    sample = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || wr_en) && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_idle timeout busy=%0b wr_en=%0b required idle", busy, wr_en);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || ram_feedback !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs wr_en=%0b addr=%0d data=%h fb=%0b busy=%0b ov=%0b required all 0",
               wr_en, wr_addr, wr_data, ram_feedback, busy, overrun);
    end
  endtask

  task automatic test_single_pixel();
    int w0 = wr_en_cycles;
    do_sample(1'b1, 1'b1);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data[15:0] !== 16'd0 || wr_data[31:16] !== 16'd1) begin
      errors++;
      $display("FAIL single_first_beat wr_en=%0b addr=%0d lane1=%0d required 1/0/1", wr_en, wr_addr, wr_data[31:16]);
    end
    repeat (11) step();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd2816 || wr_data[15:0] !== 16'd176 || wr_data[255:240] !== 16'd191) begin
      errors++;
      $display("FAIL single_last_beat addr=%0d lane0=%0d lane15=%0d required 2816/176/191",
               wr_addr, wr_data[15:0], wr_data[255:240]);
    end
    wait_idle();
    checks++;
    if (wr_en_cycles - w0 != 12 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_count wr_en_cycles=%0d left=%0d required 12/0", wr_en_cycles - w0, sb.size());
    end
  endtask

  task automatic test_backpressure();
    int w0 = wr_en_cycles;
    logic [ADDR_W-1:0] a;
    logic [WORD_W-1:0] d;
    do_sample(1'b1, 1'b0);
    repeat (5) step();
    wr_ready = 1'b0;
    a = wr_addr;
    d = wr_data;
    checks++;
    if (a !== ADDR_W'(5 * WOUT * WOUT + exp_pix - 1)) begin
      errors++;
      $display("FAIL bp_beat5_addr addr=%0d required %0d", a, 5 * WOUT * WOUT + exp_pix - 1);
    end
    repeat (3) begin
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== a || wr_data !== d) begin
        errors++;
        $display("FAIL bp_hold wr_en=%0b addr=%0d required 1/%0d, data held=%0b", wr_en, wr_addr, a, wr_data === d);
      end
    end
    wr_ready = 1'b1;
    wait_idle();
    checks++;
    if (wr_en_cycles - w0 != 15 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_count wr_en_cycles=%0d left=%0d required 15/0", wr_en_cycles - w0, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_en_cycles;
    run_max = 0;
    do_sample(1'b1, 1'b0);
    do_sample(1'b1, 1'b0);
    wait_idle();
    checks++;
    if (wr_en_cycles - w0 != 24 || run_max != 24 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b cycles=%0d run=%0d left=%0d required 24/24/0", wr_en_cycles - w0, run_max, sb.size());
    end
  endtask

  task automatic test_overrun();
    logic exp_ov;
`ifdef FIRE7_OFM_WRITER_OVERRUN_EN
    exp_ov = 1'b1;
`else
    exp_ov = 1'b0;
`endif
    do_sample(1'b1, 1'b0);
    do_sample(1'b1, 1'b0);
    do_sample(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || overrun !== exp_ov) begin
      errors++;
      $display("FAIL overrun_set busy=%0b ov=%0b required 1/%0b", busy, overrun, exp_ov);
    end
    repeat (50) step();
    wait_idle();
    checks++;
    if (overrun !== exp_ov || sb.size() != 0) begin
      errors++;
      $display("FAIL overrun_sticky ov=%0b left=%0d required %0b/0", overrun, sb.size(), exp_ov);
    end
  endtask

  task automatic test_layer_clr();
    layer_clr = 1'b1;
    step();
    layer_clr = 1'b0;
    exp_pix = 0;
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0) begin
      errors++;
      $display("FAIL layer_clr ov=%0b busy=%0b wr_en=%0b addr=%0d required all 0", overrun, busy, wr_en, wr_addr);
    end
  endtask

  task automatic test_full_layer();
    int w0 = wr_count;
    int w1;
    fb_count = 0;
    for (int p = 0; p < WOUT * WOUT; p++) begin
      do_sample(1'b1, 1'b0);
      repeat (64) step();
    end
    checks++;
    if (wr_count - w0 != 3072 || last_wr_addr !== 12'd3071 || sb.size() != 0) begin
      errors++;
      $display("FAIL layer_writes count=%0d last_addr=%0d left=%0d required 3072/3071/0",
               wr_count - w0, last_wr_addr, sb.size());
    end
    checks++;
    if (fb_count != 1 || fb_cyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL layer_feedback pulses=%0d at=%0d required 1 at %0d", fb_count, fb_cyc, last_wr_cyc + 1);
    end
    w1 = wr_count;
    do_sample(1'b0, 1'b0);
    repeat (30) step();
    checks++;
    if (wr_count != w1 || busy !== 1'b0 || overrun !== 1'b0 || fb_count != 1) begin
      errors++;
      $display("FAIL extra_sample writes=%0d busy=%0b ov=%0b fb=%0d required 0/0/0/1",
               wr_count - w1, busy, overrun, fb_count);
    end
  endtask

  task automatic test_reset_mid_write();
    test_layer_clr();
    do_sample(1'b1, 1'b0);
    repeat (7) step();
    checks++;
    if (wr_addr !== 12'd1792) begin
      errors++;
      $display("FAIL mid_beat7 addr=%0d required 1792", wr_addr);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || ram_feedback !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset wr_en=%0b addr=%0d fb=%0b busy=%0b ov=%0b required all 0",
               wr_en, wr_addr, ram_feedback, busy, overrun);
    end
    sb.delete();
    exp_pix = 0;
    step();
    rst = 1'b1;
    step();
    do_sample(1'b1, 1'b0);
    checks++;
    if (wr_addr !== 12'd0 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first addr=%0d wr_en=%0b required 0/1", wr_addr, wr_en);
    end
    wait_idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL post_reset_left left=%0d required 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    layer_clr = 1'b0;
    sample = 1'b0;
    wr_ready = 1'b1;
    for (int c = 0; c < DSP_NO; c++) ofm_in[c] = '0;
    repeat (3) step();
    test_reset();
    rst = 1'b1;
    step();
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_layer_clr();
    test_full_layer();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fire7_expand1_ofm_writer.md
Name: fire7_expand1_ofm_writer

Overview:
- Downstream stage of the fire7 expand-1x1 layer; consumes its per-pixel 192-channel output vector and writes it into the fire7 output feature-map RAM.
- Captures the vector on the producer's sample pulse, double-buffered, and serialises it as LANES-wide words in channel-major layout.
- After all WOUT*WOUT pixels are committed, pulses ram_feedback back to the producer, which releases the producer's finish.

Parameters:
- DSP_NO, 192, channels per pixel vector.
- WIDTH, 16, bits per channel value.
- LANES, 16, channels per RAM word. DSP_NO must be divisible by LANES.
- WOUT, 16, output feature-map side. Pixels per layer = WOUT*WOUT.
- BEATS, DSP_NO/LANES (12), RAM words per pixel.
- ADDR_W, $clog2(WOUT*WOUT*BEATS) (12), RAM address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- layer_clr  in  1  synchronous restart: clears counters, buffers, flags
- sample  in  1  one-cycle pulse; ofm_in is valid on this cycle
- ofm_in  in  DSP_NO x WIDTH (unpacked array)  producer output vector
- wr_ready  in  1  RAM accepts a write this cycle
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM word address
- wr_data  out  LANES*WIDTH  channel (beat*LANES+k) on bits [k*WIDTH +: WIDTH]
- ram_feedback  out  1  one-cycle pulse: layer fully written
- busy  out  1  any buffer occupied
- overrun  out  1  sticky error flag

Behaviour:
- Reset (rst low) or layer_clr: wr_en=0, wr_addr=0, wr_data=0, ram_feedback=0, busy=0, overrun=0, pixel/beat counters=0, both buffers empty, FSM=IDLE.
- Two buffers, ACTIVE (being written) and PENDING.
- On sample, ofm_in is copied to the first free buffer: ACTIVE if empty, else PENDING.
- sample while both buffers are full: vector dropped; pixel index not advanced; overrun handling per Optional Feature.
- FSM states:
  - IDLE: ACTIVE empty.
  - WRITE: driving beats of ACTIVE.
  - DONE: one cycle; pulses ram_feedback, then returns to IDLE.
- WRITE: wr_en=1 continuously; wr_data = ACTIVE channels [beat*LANES +: LANES]; wr_addr = beat*WOUT*WOUT + pix.
- beat advances only on wr_en && wr_ready. With wr_ready low, wr_en/wr_addr/wr_data hold stable.
- Latency: sample at edge T moves FSM to WRITE; first wr_en is high in cycle T+1. With wr_ready held high, a pixel takes exactly BEATS cycles.
- On accepting the last beat (beat=BEATS-1):
  - beat wraps to 0; pix increments.
  - If PENDING is full, it moves to ACTIVE and WRITE continues with no bubble.
  - Else, if pix was WOUT*WOUT-1, go to DONE; otherwise go to IDLE.
- sample coinciding with the last-beat accept: the PENDING->ACTIVE move and the new capture both happen in that cycle; the new vector lands in PENDING. No drop.
- After DONE, further samples are ignored (no write, no overrun) until layer_clr.
- busy = ACTIVE full OR PENDING full.
- Reset mid-write: the partial pixel is abandoned; RAM contents are not defined by this block.

Optional Feature:
- Macro FIRE7_OFM_WRITER_OVERRUN_EN.
- Defined:
  - Dropped sample sets overrun=1, sticky until rst/layer_clr.
  - ram_feedback is withheld at layer end while overrun=1, so the producer never reports finish on corrupt data.
- Undefined:
  - overrun tied 0.
  - Drops are silent; ram_feedback pulses once WOUT*WOUT pixels have actually been written.

Test Plan:
- Single pixel, wr_ready=1, ofm_in[c]=c: sample at T -> wr_en high T+1..T+12; beat 0 gives wr_addr=0, wr_data lane k=k; beat 11 gives wr_addr=11*256=2816, lanes 176..191.
- Backpressure: wr_ready low for 3 cycles at beat 5 -> wr_addr/wr_data held for those 3 cycles; 15 total wr_en cycles; no beat skipped or duplicated.
- Back-to-back samples 1 cycle apart -> 24 consecutive wr_en cycles; pixel 1 beat 0 at wr_addr=1; no bubble.
- Third sample while both buffers full -> vector dropped. With macro: overrun=1 and stays 1 after 50 cycles. Without macro: overrun=0.
- Full layer: 256 samples spaced 65 cycles, wr_ready=1 -> 3072 writes, last at wr_addr=3071; ram_feedback high exactly one cycle after the final beat; a 257th sample produces no write.
- Async rst low mid-WRITE (beat 7) -> all outputs 0 immediately. After release, a new sample writes pixel 0 from wr_addr=0.
